// File: rtl/data_path.sv
// 8-bit accumulator datapath: IR, PC, A, add/sub, 32x8 RAM, select muxes.
// Latency: registers load on the rising edge; RAM read and all status outputs are combinational.
// Backpressure: none, the control FSM sequences every load and write cycle by cycle.
module data_path #(
    parameter int    DATA_W   = 8,
    parameter int    ADDR_W   = 5,
    parameter string MEM_FILE = "program.hex"
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              IRload,
    input  logic              JMPmux,
    input  logic              PCload,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic [1:0]        Asel,
    input  logic              Aload,
    input  logic              Sub,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic [2:0]        IR75,
    output logic              Aeq0,
    output logic              Apos,
    output logic [ADDR_W-1:0] MeminstOut,
    output logic [DATA_W-1:0] regAOut,
    output logic [DATA_W-1:0] RAMout
);

    localparam int DEPTH = 1 << ADDR_W;

    // A input select encodings
    localparam logic [1:0] ASEL_ALU  = 2'b00;
    localparam logic [1:0] ASEL_IN   = 2'b01;
    localparam logic [1:0] ASEL_RAM  = 2'b10;
    localparam logic [1:0] ASEL_ZERO = 2'b11;

    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q,  a_d;

    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] ram_rd;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Low address bits of IR serve both as jump target and as direct operand address.
    assign ir_addr = ir_q[ADDR_W-1:0];

    // PC increment relies on natural wrap of the ADDR_W-bit sum (31 -> 0).
    assign pc_inc = pc_q + ADDR_W'(1);

    // Address mux, combinational RAM read and add/sub unit.
    always_comb begin
        mem_addr = Meminst ? ir_addr : pc_q;
        ram_rd   = mem[mem_addr];
        // Carry and borrow are dropped; result is mod 2^DATA_W two's complement.
        alu_res  = Sub ? (a_q - ram_rd) : (a_q + ram_rd);
    end

    // Next-state selection for IR, PC and A; every term uses pre-edge values, no bypass.
    always_comb begin
        ir_d = ir_q;
        pc_d = pc_q;
        a_d  = a_q;
        if (IRload) begin
            ir_d = ram_rd;
        end
        if (PCload) begin
            pc_d = JMPmux ? ir_addr : pc_inc;
        end
        if (Aload) begin
            unique case (Asel)
                ASEL_ALU:  a_d = alu_res;
                ASEL_IN:   a_d = in;
                ASEL_RAM:  a_d = ram_rd;
                ASEL_ZERO: a_d = '0;
                default:   a_d = a_q;
            endcase
        end
    end

    // Architectural registers, cleared asynchronously while clear is low.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            ir_q <= '0;
            pc_q <= '0;
            a_q  <= '0;
        end else begin
            ir_q <= ir_d;
            pc_q <= pc_d;
            a_q  <= a_d;
        end
    end

    // Synchronous RAM write of the pre-edge A; an edge seen while clear is low writes nothing.
    always_ff @(posedge clk) begin
        if (MemWr && clear) begin
            mem[mem_addr] <= a_q;
        end
    end

    // Status and visible outputs are decoded straight from the current registers.
    always_comb begin
        out        = a_q;
        regAOut    = a_q;
        IR75       = ir_q[7:5];
        Aeq0       = (a_q == '0);
        Apos       = ~a_q[DATA_W-1];
        MeminstOut = mem_addr;
        RAMout     = ram_rd;
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for the accumulator datapath.
// Latency: inputs are driven 1 time unit after a rising edge and outputs checked before the next edge.
// Backpressure: none, every step advances a fixed number of clock edges.
module tb_data_path;

    logic       clk;
    logic       clear;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
    logic [1:0] Asel;
    logic [7:0] in;
    logic [7:0] out, regAOut, RAMout;
    logic [2:0] IR75;
    logic       Aeq0, Apos;
    logic [4:0] MeminstOut;

    int n_cmp;
    int n_bad;

    data_path dut (
        .clk        (clk),
        .clear      (clear),
        .IRload     (IRload),
        .JMPmux     (JMPmux),
        .PCload     (PCload),
        .Meminst    (Meminst),
        .MemWr      (MemWr),
        .Asel       (Asel),
        .Aload      (Aload),
        .Sub        (Sub),
        .in         (in),
        .out        (out),
        .IR75       (IR75),
        .Aeq0       (Aeq0),
        .Apos       (Apos),
        .MeminstOut (MeminstOut),
        .regAOut    (regAOut),
        .RAMout     (RAMout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0;
        MemWr = 0; Aload = 0; Sub = 0; Asel = 2'b00;
    endtask

    // Load A from the external input in one edge.
    task automatic load_a(input logic [7:0] v);
        idle();
        in = v; Asel = 2'b01; Aload = 1;
        tick();
        idle();
    endtask

    // Write A into RAM at the currently selected address.
    task automatic store_a(input logic sel_ir);
        idle();
        Meminst = sel_ir; MemWr = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        clear = 0;
        IRload = 1; JMPmux = 1; PCload = 1; Meminst = 1; MemWr = 1;
        Asel = 2'b01; Aload = 1; Sub = 1; in = 8'hFF;
        tick(); tick();
        n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset_out got %h want 00", out); end
        n_cmp++; if (regAOut !== 8'h00) begin n_bad++; $display("FAIL reset_regA got %h want 00", regAOut); end
        n_cmp++; if (IR75 !== 3'b000) begin n_bad++; $display("FAIL reset_IR75 got %b want 000", IR75); end
        n_cmp++; if (Aeq0 !== 1'b1 || Apos !== 1'b1) begin n_bad++; $display("FAIL reset_flags got Aeq0=%b Apos=%b want 1 1", Aeq0, Apos); end
        idle();
        #1;
        n_cmp++; if (MeminstOut !== 5'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", MeminstOut); end
        n_cmp++; if (RAMout !== 8'h00) begin n_bad++; $display("FAIL reset_ram got %h want 00", RAMout); end
        clear = 1;
        tick();
    endtask

    task automatic test_load_store();
        load_a(8'h05);
        n_cmp++; if (out !== 8'h05) begin n_bad++; $display("FAIL load_in got %h want 05", out); end
        n_cmp++; if (Aeq0 !== 1'b0 || Apos !== 1'b1) begin n_bad++; $display("FAIL load_flags got Aeq0=%b Apos=%b want 0 1", Aeq0, Apos); end
        store_a(1'b0);
        n_cmp++; if (RAMout !== 8'h05) begin n_bad++; $display("FAIL store_mem0 got %h want 05", RAMout); end
    endtask

    task automatic test_fetch();
        load_a(8'hA3);
        store_a(1'b0);
        IRload = 1; PCload = 1; JMPmux = 0;
        tick();
        idle();
        n_cmp++; if (IR75 !== 3'b101) begin n_bad++; $display("FAIL fetch_IR75 got %b want 101", IR75); end
        n_cmp++; if (MeminstOut !== 5'd1) begin n_bad++; $display("FAIL fetch_pc got %0d want 1", MeminstOut); end
        Meminst = 1;
        #1;
        n_cmp++; if (MeminstOut !== 5'd3) begin n_bad++; $display("FAIL fetch_iraddr got %0d want 3", MeminstOut); end
        idle();
    endtask

    task automatic test_addsub();
        // mem[1] = 07 via PC address
        load_a(8'h07);
        store_a(1'b0);
        load_a(8'h05);
        Asel = 2'b00; Sub = 0; Aload = 1;
        tick();
        idle();
        n_cmp++; if (out !== 8'h0C) begin n_bad++; $display("FAIL add got %h want 0c", out); end
        load_a(8'h05);
        Asel = 2'b00; Sub = 1; Aload = 1;
        tick();
        idle();
        n_cmp++; if (regAOut !== 8'hFE) begin n_bad++; $display("FAIL sub got %h want fe", regAOut); end
        n_cmp++; if (Apos !== 1'b0 || Aeq0 !== 1'b0) begin n_bad++; $display("FAIL sub_flags got Aeq0=%b Apos=%b want 0 0", Aeq0, Apos); end
    endtask

    task automatic test_jump_wrap();
        // mem[1] = 5F -> IR[4:0] = 31, opcode 010
        load_a(8'h5F);
        store_a(1'b0);
        IRload = 1;
        tick();
        idle();
        n_cmp++; if (IR75 !== 3'b010) begin n_bad++; $display("FAIL jmp_IR75 got %b want 010", IR75); end
        JMPmux = 1; PCload = 1;
        tick();
        idle();
        n_cmp++; if (MeminstOut !== 5'd31) begin n_bad++; $display("FAIL jmp_pc got %0d want 31", MeminstOut); end
        PCload = 1;
        tick();
        idle();
        n_cmp++; if (MeminstOut !== 5'd0) begin n_bad++; $display("FAIL wrap_pc got %0d want 0", MeminstOut); end
        n_cmp++; if (RAMout !== 8'hA3) begin n_bad++; $display("FAIL wrap_ram got %h want a3", RAMout); end
        Asel = 2'b11; Aload = 1;
        tick();
        idle();
        n_cmp++; if (out !== 8'h00 || Aeq0 !== 1'b1 || Apos !== 1'b1) begin n_bad++; $display("FAIL zero_a got out=%h Aeq0=%b Apos=%b want 00 1 1", out, Aeq0, Apos); end
    endtask

    task automatic test_back_to_back();
        // IR=5F, PC=0, mem[0]=A3: jump takes old IR while IR loads A3
        IRload = 1; PCload = 1; JMPmux = 1;
        tick();
        idle();
        n_cmp++; if (MeminstOut !== 5'd31) begin n_bad++; $display("FAIL b2b_pc got %0d want 31", MeminstOut); end
        n_cmp++; if (IR75 !== 3'b101) begin n_bad++; $display("FAIL b2b_IR75 got %b want 101", IR75); end
        // IR loads old mem[31]=00 while A=42 is written there
        load_a(8'h42);
        MemWr = 1; IRload = 1;
        tick();
        idle();
        n_cmp++; if (IR75 !== 3'b000) begin n_bad++; $display("FAIL b2b_irold got %b want 000", IR75); end
        n_cmp++; if (RAMout !== 8'h42) begin n_bad++; $display("FAIL b2b_mem31 got %h want 42", RAMout); end
        // IR=00 -> direct address 0 holds A3
        Meminst = 1; Asel = 2'b10; Aload = 1;
        tick();
        idle();
        n_cmp++; if (out !== 8'hA3 || Apos !== 1'b0) begin n_bad++; $display("FAIL ramload got out=%h Apos=%b want a3 0", out, Apos); end
    endtask

    task automatic test_async_clear();
        // A=A3, PC=31, mem[31]=42, mem[0]=A3
        Asel = 2'b01; in = 8'h77; Aload = 1;
        #3;
        clear = 0;
        #1;
        n_cmp++; if (out !== 8'h00 || Aeq0 !== 1'b1) begin n_bad++; $display("FAIL aclr_a got out=%h Aeq0=%b want 00 1", out, Aeq0); end
        n_cmp++; if (MeminstOut !== 5'd0) begin n_bad++; $display("FAIL aclr_pc got %0d want 0", MeminstOut); end
        MemWr = 1;
        tick();
        n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL aclr_hold got %h want 00", out); end
        idle();
        clear = 1;
        #1;
        n_cmp++; if (RAMout !== 8'hA3) begin n_bad++; $display("FAIL aclr_mem0 got %h want a3", RAMout); end
        PCload = 1; JMPmux = 0;
        tick();
        idle();
        Meminst = 0;
        #1;
        // PC walked 0 -> 1; mem[1] = 5F must still be there
        n_cmp++; if (RAMout !== 8'h5F) begin n_bad++; $display("FAIL aclr_mem1 got %h want 5f", RAMout); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        in = 8'h00;
        clear = 0;
        test_reset();
        test_load_store();
        test_fetch();
        test_addsub();
        test_jump_wrap();
        test_back_to_back();
        test_async_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
